// File: rtl/opamp_trim_sar_cal_if.sv
// Control / manual-write bundle for the op-amp offset-trim calibrator.
// Master drives requests and writes; slave (calibrator) returns status.
interface opamp_trim_sar_cal_if #(
    parameter int NCH    = 2,
    parameter int TRIM_W = 6
);
    logic                   start;
    logic                   abort;
    logic                   wr_en;
    logic [$clog2(NCH):0]   wr_ch;
    logic [TRIM_W-1:0]      wr_data;
    logic                   busy;
    logic                   done;

    modport master (
        output start, abort, wr_en, wr_ch, wr_data,
        input  busy, done
    );

    modport slave (
        input  start, abort, wr_en, wr_ch, wr_data,
        output busy, done
    );
endinterface

// File: rtl/opamp_trim_sar_cal.sv
// Per-channel SAR offset-trim calibrator for a bank of op-amps.
// Auto-zeroes each channel in turn and binary-searches its trim code.
module opamp_trim_sar_cal #(
    parameter int NCH        = 2,
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmp_in,
    output logic [NCH*TRIM_W-1:0]   trim_code,
    output logic [NCH-1:0]          az_en,
    output logic [$clog2(NCH):0]    cal_ch,
    opamp_trim_sar_cal_if.slave     ctl
);
    localparam int CW    = $clog2(NCH) + 1;
    localparam int BW    = $clog2(TRIM_W);
    localparam int CNT_W = $clog2(SETTLE_CYC);

    localparam logic [TRIM_W-1:0] MID  = TRIM_W'(1) << (TRIM_W - 1);
    localparam logic [CW-1:0]     LAST = CW'(NCH - 1);
    localparam logic [BW-1:0]     TOPB = BW'(TRIM_W - 1);
    localparam logic [CNT_W-1:0]  CNT0 = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SETTLE,
        DECIDE,
        NEXT_CH,
        DONE
    } state_t;

    state_t             state;
    logic [BW-1:0]      b;
    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic               done;
    logic               cmp_m;
    logic               cmp_s;
    logic [TRIM_W-1:0]  cur;
    logic [TRIM_W-1:0]  clr;
    logic [TRIM_W-1:0]  setb;
    logic [TRIM_W-1:0]  nxt;

    assign ctl.busy = busy;
    assign ctl.done = done;

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_m <= 1'b0;
            cmp_s <= 1'b0;
        end else begin
            cmp_m <= cmp_in;
            cmp_s <= cmp_m;
        end
    end

    // Next code for the active channel: drop bit b if too high, trial next bit.
    always_comb begin
        cur  = trim_code[int'(cal_ch)*TRIM_W +: TRIM_W];
        clr  = TRIM_W'(1) << b;
        setb = '0;
        if (b != '0)
            setb = TRIM_W'(1) << (b - BW'(1));
        nxt = (cmp_s ? (cur & ~clr) : cur) | setb;
    end

    // Calibration sequencer, trim registers and manual write path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            trim_code <= {NCH{MID}};
            az_en     <= '0;
            cal_ch    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            b         <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            if (ctl.abort && busy) begin
                // A channel still searching is left at mid-scale.
                state <= IDLE;
                az_en <= '0;
                busy  <= 1'b0;
                if (state != NEXT_CH)
                    trim_code[int'(cal_ch)*TRIM_W +: TRIM_W] <= MID;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ctl.start) begin
                            cal_ch <= '0;
                            busy   <= 1'b1;
                            state  <= INIT;
                        end else if (ctl.wr_en && ctl.wr_ch <= LAST) begin
                            trim_code[int'(ctl.wr_ch)*TRIM_W +: TRIM_W] <= ctl.wr_data;
                        end
                    end
                    INIT: begin
                        az_en <= NCH'(1) << cal_ch;
                        trim_code[int'(cal_ch)*TRIM_W +: TRIM_W] <= MID;
                        b     <= TOPB;
                        cnt   <= CNT0;
                        state <= SETTLE;
                    end
                    SETTLE: begin
                        if (cnt == '0)
                            state <= DECIDE;
                        else
                            cnt <= cnt - CNT_W'(1);
                    end
                    DECIDE: begin
                        trim_code[int'(cal_ch)*TRIM_W +: TRIM_W] <= nxt;
                        if (b == '0) begin
                            state <= NEXT_CH;
                        end else begin
                            b     <= b - BW'(1);
                            cnt   <= CNT0;
                            state <= SETTLE;
                        end
                    end
                    NEXT_CH: begin
                        az_en <= '0;
                        if (cal_ch == LAST) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            cal_ch <= cal_ch + CW'(1);
                            state  <= INIT;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
